cache_nway: RTL
===============

# cache_nway

Parametrised N-way set-associative, write-back, write-allocate L1 cache controller with true-LRU replacement. It replaces the fixed instruction and data caches: one instance is used per stream, with `WAYS`/`SETS`/`LINE_BYTES` set per instance. It accepts trace commands on a valid/ready request port, issues line read and write-back requests to the next-level cache over a second handshake, and emits hit/miss pulses to the statistics block. Tag state only: no data array.

## Interface
- `ADDR_W`, 32, request address width
- `SETS`, 64, number of sets (power of 2, ≥2)
- `WAYS`, 4, associativity (power of 2, ≥2)
- `LINE_BYTES`, 64, line size (power of 2)
- `clk` in 1 clock, all state on rising edge
- `rst_n` in 1 asynchronous active-low reset
- `req_valid` in 1 command present
- `req_ready` out 1 controller idle, command accepted on `req_valid && req_ready`
- `req_cmd` in 4 command: 0 read, 1 write, 2 ifetch, 3 invalidate, 8 clear; others are no-ops
- `req_addr` in ADDR_W byte address
- `resp_valid` out 1 one-cycle pulse, command complete
- `hit` out 1 one-cycle pulse, lookup hit (cmds 0/1/2)
- `miss` out 1 one-cycle pulse, lookup miss (cmds 0/1/2)
- `nxt_valid` out 1 next-level request pending
- `nxt_ready` in 1 next level accepts, transfer on `nxt_valid && nxt_ready`
- `nxt_wb` out 1 1 = write-back of dirty victim, 0 = line fill read
- `nxt_addr` out ADDR_W line-aligned address (offset bits zero)

## Operation
- Address split: OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W−IDX_W−OFF_W. Index = addr[OFF_W+IDX_W−1:OFF_W], tag = upper bits.
- Per line: valid, dirty, tag, lru[log2(WAYS)−1:0].
- FSM states: IDLE, LOOKUP, EVICT, FILL, UPDATE, CLEAR.
- IDLE: `req_ready`=1. On accept, latch cmd/addr. Cmd 8 → CLEAR. Any other cmd → LOOKUP.
- LOOKUP, cmds 0/1/2:
  - Hit: pulse `hit` and `resp_valid`, touch the LRU of the hit way, set dirty if cmd 1, go to IDLE.
  - Miss: pulse `miss` and select a victim. The victim is the lowest-index invalid way; if no way is invalid, the way with lru==0. A valid and dirty victim → EVICT, otherwise → FILL.
- LOOKUP, cmd 3: on hit, clear valid; dirty data is discarded with no write-back. LRU is unchanged, there is no hit/miss pulse, `resp_valid` pulses, → IDLE.
- LOOKUP, unknown cmd: `resp_valid` pulses, no state change, → IDLE.
- EVICT: `nxt_valid`=1, `nxt_wb`=1, `nxt_addr`={victim tag, index, 0}. On `nxt_ready` → FILL.
- FILL: `nxt_valid`=1, `nxt_wb`=0, `nxt_addr`={req tag, index, 0}. On `nxt_ready` → UPDATE.
- UPDATE: write victim tag, set valid=1, set dirty=(cmd==1), touch LRU, pulse `resp_valid`, → IDLE.
- LRU touch for way w with old value v: lru[w]←WAYS−1, and every way with lru>v decrements. The lru values in a set always form a permutation of 0..WAYS−1.
- CLEAR: a counter walks set 0..SETS−1, one set per cycle, clearing valid and dirty and setting lru[w]=w. There are no write-backs. `resp_valid` pulses on the cycle the last set is cleared, → IDLE.

## Timing
- Reset (async assert, any state): state=IDLE, all valid/dirty=0, lru[w]=w, clear counter=0. Outputs: `req_ready`=1, all others 0.
- Reset mid-transaction: `nxt_valid` drops immediately and the request is abandoned.
- Hit latency: accept at edge N; `hit`+`resp_valid` are high in the cycle after edge N (LOOKUP); `req_ready` is high again one cycle later.
- Clean miss: LOOKUP, then FILL for ≥1 cycle, then UPDATE. With `nxt_ready` tied high, `resp_valid` asserts 3 cycles after accept.
- Dirty miss: adds ≥1 EVICT cycle.
- `nxt_valid`, `nxt_wb` and `nxt_addr` are held stable until the handshake completes. `nxt_valid` never deasserts without `nxt_ready` except on reset.
- Clear: SETS cycles in CLEAR, `req_ready` low throughout.
- `req_ready` is 0 in every state except IDLE. `req_valid` while not ready is ignored, not queued.
- `hit` and `miss` are mutually exclusive and never both high.

## Test plan
Configuration for all scenarios: WAYS=4, SETS=4, LINE_BYTES=64, ADDR_W=32, `nxt_ready`=1 unless stated.
- Cold read 0x0000_0100 → `miss`; FILL with `nxt_wb`=0, `nxt_addr`=0x100; `resp_valid` at accept+3. Re-read 0x0000_013C → `hit`, `resp_valid` at accept+1.
- Five reads to set 0, tags 1..5 (addrs 0x100, 0x200, 0x300, 0x400, 0x500), then read 0x100 → 6 misses. The fifth and sixth fills evict tags 1 and 2 (lru==0) without write-back.
- Write 0x0000_0040 (miss), then fill 4 other tags into set 1 → an EVICT with `nxt_wb`=1, `nxt_addr`=0x40 precedes the fill. Hold `nxt_ready`=0 for 5 cycles: outputs stay stable and `req_ready` stays 0.
- Read 0x80, invalidate 0x80, read 0x80 → miss, resp only, miss. No hit/miss pulse on the invalidate.
- Fill 3 lines, issue clear → `req_ready` low exactly 4 cycles. All subsequent reads miss and lru is restored to w.
- Assert `rst_n`=0 during FILL → `nxt_valid`=0 immediately, `req_ready`=1. A prior valid line now misses.

Source files
------------

// File: rtl/cache_nway.sv
`default_nettype none
// ============================================================================
// cache_nway : N-way set-associative write-back/write-allocate tag controller
//              with true-LRU replacement (tag state only, no data array).
// Revision   : 1.0
// ============================================================================
module cache_nway #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_cmd,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_resp_valid,
  output logic              o_hit,
  output logic              o_miss,
  output logic              o_nxt_valid,
  input  logic              i_nxt_ready,
  output logic              o_nxt_wb,
  output logic [ADDR_W-1:0] o_nxt_addr
);
  localparam int c_OFF_W = $clog2(LINE_BYTES);
  localparam int c_IDX_W = $clog2(SETS);
  localparam int c_TAG_W = ADDR_W - c_IDX_W - c_OFF_W;
  localparam int c_LRU_W = $clog2(WAYS);
  localparam logic [3:0] c_CMD_WR  = 4'd1;
  localparam logic [3:0] c_CMD_INV = 4'd3;
  localparam logic [3:0] c_CMD_CLR = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_UPDATE, S_CLEAR
  } state_t;

  state_t                     r_state, w_next;
  logic [WAYS-1:0]            r_valid [SETS];
  logic [WAYS-1:0]            r_dirty [SETS];
  logic [c_TAG_W-1:0]         r_tag   [SETS][WAYS];
  logic [c_LRU_W-1:0]         r_lru   [SETS][WAYS];
  logic [3:0]                 r_cmd;
  logic [ADDR_W-1:c_OFF_W]    r_addr;
  logic [c_LRU_W-1:0]         r_victim;
  logic [c_IDX_W-1:0]         r_clr_cnt;

  logic [c_IDX_W-1:0]         w_idx;
  logic [c_TAG_W-1:0]         w_tag;
  logic                       w_access, w_hit, w_inv_found;
  logic [c_LRU_W-1:0]         w_hit_way, w_inv_way, w_lru0_way, w_victim;
  logic                       w_touch_en;
  logic [c_LRU_W-1:0]         w_touch_way;
  logic                       w_unused;

  assign w_unused = ^i_req_addr[c_OFF_W-1:0];
  assign w_idx    = r_addr[c_OFF_W +: c_IDX_W];
  assign w_tag    = r_addr[ADDR_W-1 -: c_TAG_W];
  assign w_access = (r_cmd <= 4'd2);

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru0_way  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_LRU_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = c_LRU_W'(w);
      end
      if (r_lru[w_idx][w] == '0) w_lru0_way = c_LRU_W'(w);
    end
    w_victim = w_inv_found ? w_inv_way : w_lru0_way;
  end

  assign w_touch_en  = ((r_state == S_LOOKUP) && w_access && w_hit) || (r_state == S_UPDATE);
  assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_hit        = 1'b0;
    o_miss       = 1'b0;
    o_nxt_valid  = 1'b0;
    o_nxt_wb     = 1'b0;
    o_nxt_addr   = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = (i_req_cmd == c_CMD_CLR) ? S_CLEAR : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_access && !w_hit) begin
          o_miss = 1'b1;
          w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_EVICT : S_FILL;
        end else begin
          o_hit        = w_access;
          o_resp_valid = 1'b1;
          w_next       = S_IDLE;
        end
      end
      S_EVICT: begin
        o_nxt_valid = 1'b1;
        o_nxt_wb    = 1'b1;
        o_nxt_addr  = {r_tag[w_idx][r_victim], w_idx, {c_OFF_W{1'b0}}};
        if (i_nxt_ready) w_next = S_FILL;
      end
      S_FILL: begin
        o_nxt_valid = 1'b1;
        o_nxt_addr  = {w_tag, w_idx, {c_OFF_W{1'b0}}};
        if (i_nxt_ready) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        o_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      S_CLEAR: begin
        if (r_clr_cnt == c_IDX_W'(SETS-1)) begin
          o_resp_valid = 1'b1;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_addr    <= '0;
      r_victim  <= '0;
      r_clr_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          r_lru[s][w] <= c_LRU_W'(w);
        end
      end
    end else begin
      // Touched way becomes MRU; ways more recent than it slide down one rank.
      if (w_touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (c_LRU_W'(w) == w_touch_way)
            r_lru[w_idx][w] <= c_LRU_W'(WAYS-1);
          else if (r_lru[w_idx][w] > r_lru[w_idx][w_touch_way])
            r_lru[w_idx][w] <= r_lru[w_idx][w] - 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_cmd  <= i_req_cmd;
            r_addr <= i_req_addr[ADDR_W-1:c_OFF_W];
          end
        end
        S_LOOKUP: begin
          if (w_access) begin
            if (w_hit && (r_cmd == c_CMD_WR)) r_dirty[w_idx][w_hit_way] <= 1'b1;
            if (!w_hit) r_victim <= w_victim;
          end else if ((r_cmd == c_CMD_INV) && w_hit) begin
            r_valid[w_idx][w_hit_way] <= 1'b0;
            r_dirty[w_idx][w_hit_way] <= 1'b0;
          end
        end
        S_UPDATE: begin
          r_tag[w_idx][r_victim]   <= w_tag;
          r_valid[w_idx][r_victim] <= 1'b1;
          r_dirty[w_idx][r_victim] <= (r_cmd == c_CMD_WR);
        end
        S_CLEAR: begin
          r_valid[r_clr_cnt] <= '0;
          r_dirty[r_clr_cnt] <= '0;
          for (int w = 0; w < WAYS; w++) r_lru[r_clr_cnt][w] <= c_LRU_W'(w);
          r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
